// File: rtl/axi4_lite_fifo_bridge.sv
// AXI4-Lite slave front end that forwards joined write requests and read requests into FIFOs
// and returns B/R responses from FWFT response FIFOs, with per-direction outstanding limits.
module axi4_lite_fifo_bridge #(
  parameter int unsigned G_ADDR_W    = 28,
  parameter int unsigned G_DATA_W    = 32,
  parameter int unsigned G_MAX_OUTST = 4
) (
  input  logic                                 aclk_i,
  input  logic                                 areset_n_i,
  input  logic                                 awvalid_i,
  output logic                                 awready_o,
  input  logic [G_ADDR_W-1:0]                  awaddr_i,
  input  logic [2:0]                           awprot_i,
  input  logic                                 wvalid_i,
  output logic                                 wready_o,
  input  logic [G_DATA_W-1:0]                  wdata_i,
  input  logic [G_DATA_W/8-1:0]                wstrb_i,
  output logic                                 bvalid_o,
  input  logic                                 bready_i,
  output logic [1:0]                           bresp_o,
  input  logic                                 arvalid_i,
  output logic                                 arready_o,
  input  logic [G_ADDR_W-1:0]                  araddr_i,
  input  logic [2:0]                           arprot_i,
  output logic                                 rvalid_o,
  input  logic                                 rready_i,
  output logic [G_DATA_W-1:0]                  rdata_o,
  output logic [1:0]                           rresp_o,
  input  logic                                 wr_req_full_i,
  output logic                                 wr_req_push_o,
  output logic [G_ADDR_W+G_DATA_W*9/8-1:0]     wr_req_data_o,
  input  logic                                 wr_resp_empty_i,
  input  logic [1:0]                           wr_resp_data_i,
  output logic                                 wr_resp_pull_o,
  input  logic                                 rd_req_full_i,
  output logic                                 rd_req_push_o,
  output logic [G_ADDR_W-1:0]                  rd_req_data_o,
  input  logic                                 rd_resp_empty_i,
  input  logic [G_DATA_W+1:0]                  rd_resp_data_i,
  output logic                                 rd_resp_pull_o,
  output logic [3:0]                           wr_outst_o,
  output logic [3:0]                           rd_outst_o
);

  localparam int unsigned STRB_W    = G_DATA_W / 8;
  localparam logic [3:0]  MAX_OUTST = 4'(G_MAX_OUTST);

  typedef enum logic {EMPTY, HELD} hold_t;

  hold_t               aw_st, w_st, ar_st;
  logic [G_ADDR_W-1:0] aw_addr, ar_addr;
  logic [G_DATA_W-1:0] w_data;
  logic [STRB_W-1:0]   w_strb;
  logic                wr_push, rd_push, wr_pull, rd_pull, b_hs, r_hs;
  logic                unused_prot;

  assign unused_prot = ^{awprot_i, arprot_i};

  assign awready_o = (aw_st == EMPTY);
  assign wready_o  = (w_st == EMPTY);
  assign arready_o = (ar_st == EMPTY);

  assign wr_push = (aw_st == HELD) && (w_st == HELD) && !wr_req_full_i && (wr_outst_o < MAX_OUTST);
  assign rd_push = (ar_st == HELD) && !rd_req_full_i && (rd_outst_o < MAX_OUTST);

  assign wr_req_push_o = wr_push;
  assign wr_req_data_o = {aw_addr, w_data, w_strb};
  assign rd_req_push_o = rd_push;
  assign rd_req_data_o = ar_addr;

  assign b_hs = bvalid_o && bready_i;
  assign r_hs = rvalid_o && rready_i;

  // Pulls are masked while reset is held so no response entry is consumed and lost.
  assign wr_pull = areset_n_i && !wr_resp_empty_i && (!bvalid_o || bready_i);
  assign rd_pull = areset_n_i && !rd_resp_empty_i && (!rvalid_o || rready_i);
  assign wr_resp_pull_o = wr_pull;
  assign rd_resp_pull_o = rd_pull;

  function automatic logic [3:0] next_count(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [3:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + 4'd1;
    else if (dec && !inc && cnt != '0)
      res = cnt - 4'd1;
    return res;
  endfunction

  always_ff @(posedge aclk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      aw_st   <= EMPTY;
      aw_addr <= '0;
    end else if (wr_push) begin
      aw_st <= EMPTY;
    end else if (awvalid_i && aw_st == EMPTY) begin
      aw_st   <= HELD;
      aw_addr <= awaddr_i;
    end
  end

  always_ff @(posedge aclk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      w_st   <= EMPTY;
      w_data <= '0;
      w_strb <= '0;
    end else if (wr_push) begin
      w_st <= EMPTY;
    end else if (wvalid_i && w_st == EMPTY) begin
      w_st   <= HELD;
      w_data <= wdata_i;
      w_strb <= wstrb_i;
    end
  end

  always_ff @(posedge aclk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      ar_st   <= EMPTY;
      ar_addr <= '0;
    end else if (rd_push) begin
      ar_st <= EMPTY;
    end else if (arvalid_i && ar_st == EMPTY) begin
      ar_st   <= HELD;
      ar_addr <= araddr_i;
    end
  end

  // A pull coinciding with a handshake reloads the register, giving back-to-back responses.
  always_ff @(posedge aclk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      bvalid_o <= 1'b0;
      bresp_o  <= '0;
    end else if (wr_pull) begin
      bvalid_o <= 1'b1;
      bresp_o  <= wr_resp_data_i;
    end else if (b_hs) begin
      bvalid_o <= 1'b0;
    end
  end

  always_ff @(posedge aclk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      rresp_o  <= '0;
    end else if (rd_pull) begin
      rvalid_o           <= 1'b1;
      {rdata_o, rresp_o} <= rd_resp_data_i;
    end else if (r_hs) begin
      rvalid_o <= 1'b0;
    end
  end

  always_ff @(posedge aclk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      wr_outst_o <= '0;
      rd_outst_o <= '0;
    end else begin
      wr_outst_o <= next_count(wr_outst_o, wr_push, b_hs);
      rd_outst_o <= next_count(rd_outst_o, rd_push, r_hs);
    end
  end

endmodule

// File: tb/tb_axi4_lite_fifo_bridge.sv
// Bench for axi4_lite_fifo_bridge: queue-based AXI master, response FIFO emulation and
// scoreboards for request order, response order and outstanding counts.
module tb_axi4_lite_fifo_bridge;

  localparam int AW = 28, DW = 32, SW = DW / 8, MAXO = 4, WRW = AW + DW + SW;

  logic          aclk_i = 1'b0;
  logic          areset_n_i = 1'b0;
  logic          awvalid_i = 1'b0, wvalid_i = 1'b0, arvalid_i = 1'b0;
  logic          bready_i = 1'b0, rready_i = 1'b0;
  logic [AW-1:0] awaddr_i = '0, araddr_i = '0;
  logic [2:0]    awprot_i = '0, arprot_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic [SW-1:0] wstrb_i = '0;
  logic          wr_req_full_i = 1'b0, rd_req_full_i = 1'b0;
  logic          wr_resp_empty_i = 1'b1, rd_resp_empty_i = 1'b1;
  logic [1:0]    wr_resp_data_i = '0;
  logic [DW+1:0] rd_resp_data_i = '0;

  logic           awready_o, wready_o, arready_o, bvalid_o, rvalid_o;
  logic [1:0]     bresp_o, rresp_o;
  logic [DW-1:0]  rdata_o;
  logic           wr_req_push_o, wr_resp_pull_o, rd_req_push_o, rd_resp_pull_o;
  logic [WRW-1:0] wr_req_data_o;
  logic [AW-1:0]  rd_req_data_o;
  logic [3:0]     wr_outst_o, rd_outst_o;

  axi4_lite_fifo_bridge #(.G_ADDR_W(AW), .G_DATA_W(DW), .G_MAX_OUTST(MAXO)) dut (
    .aclk_i(aclk_i), .areset_n_i(areset_n_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awprot_i(awprot_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arprot_i(arprot_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .wr_req_full_i(wr_req_full_i), .wr_req_push_o(wr_req_push_o), .wr_req_data_o(wr_req_data_o),
    .wr_resp_empty_i(wr_resp_empty_i), .wr_resp_data_i(wr_resp_data_i), .wr_resp_pull_o(wr_resp_pull_o),
    .rd_req_full_i(rd_req_full_i), .rd_req_push_o(rd_req_push_o), .rd_req_data_o(rd_req_data_o),
    .rd_resp_empty_i(rd_resp_empty_i), .rd_resp_data_i(rd_resp_data_i), .rd_resp_pull_o(rd_resp_pull_o),
    .wr_outst_o(wr_outst_o), .rd_outst_o(rd_outst_o)
  );

  always #5 aclk_i = ~aclk_i;

  int n_checks = 0, n_pass = 0;
  int valid_pct = 100;
  bit auto_resp = 1'b0;
  int wr_cnt_m = 0, rd_cnt_m = 0;
  int n_wpush = 0, n_rpush = 0, n_bpull = 0, n_rpull = 0;

  logic [AW-1:0]    aw_q[$], ar_q[$], exp_rd[$];
  logic [DW+SW-1:0] w_q[$];
  logic [WRW-1:0]   exp_wr[$];
  logic [1:0]       bq[$], exp_b[$];
  logic [DW+1:0]    rq[$], exp_r[$];

  task automatic present();
    if (!awvalid_i && aw_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      awvalid_i = 1'b1; awaddr_i = aw_q[0];
    end
    if (!wvalid_i && w_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      wvalid_i = 1'b1; {wdata_i, wstrb_i} = w_q[0];
    end
    if (!arvalid_i && ar_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      arvalid_i = 1'b1; araddr_i = ar_q[0];
    end
    wr_resp_empty_i = (bq.size() == 0);
    if (bq.size() > 0) wr_resp_data_i = bq[0];
    rd_resp_empty_i = (rq.size() == 0);
    if (rq.size() > 0) rd_resp_data_i = rq[0];
  endtask

  task automatic tick();
    logic wpush, rpush, bpull, rpull, bhs, rhs, awhs, whs, arhs, bhold, rhold;
    logic [1:0]    bresp_prev, resp;
    logic [DW+1:0] r_prev, rent;
    wpush = wr_req_push_o; rpush = rd_req_push_o;
    bpull = wr_resp_pull_o; rpull = rd_resp_pull_o;
    bhs = bvalid_o & bready_i; rhs = rvalid_o & rready_i;
    awhs = awvalid_i & awready_o; whs = wvalid_i & wready_o; arhs = arvalid_i & arready_o;
    bhold = bvalid_o & !bready_i; bresp_prev = bresp_o;
    rhold = rvalid_o & !rready_i; r_prev = {rdata_o, rresp_o};
    if (wpush) begin
      n_wpush++; n_checks++;
      if (exp_wr.size() == 0) $display("FAIL wr_push_unexpected got %h required none", wr_req_data_o);
      else if (wr_req_data_o !== exp_wr[0]) $display("FAIL wr_push_data got %h required %h", wr_req_data_o, exp_wr[0]);
      else n_pass++;
      if (exp_wr.size() > 0) void'(exp_wr.pop_front());
    end
    if (rpush) begin
      n_rpush++; n_checks++;
      if (exp_rd.size() == 0) $display("FAIL rd_push_unexpected got %h required none", rd_req_data_o);
      else if (rd_req_data_o !== exp_rd[0]) $display("FAIL rd_push_addr got %h required %h", rd_req_data_o, exp_rd[0]);
      else n_pass++;
      if (exp_rd.size() > 0) void'(exp_rd.pop_front());
    end
    if (bhs) begin
      n_checks++;
      if (exp_b.size() == 0) $display("FAIL b_unexpected got %h required none", bresp_o);
      else if (bresp_o !== exp_b[0]) $display("FAIL b_order got %h required %h", bresp_o, exp_b[0]);
      else n_pass++;
      if (exp_b.size() > 0) void'(exp_b.pop_front());
    end
    if (rhs) begin
      n_checks++;
      if (exp_r.size() == 0) $display("FAIL r_unexpected got %h required none", {rdata_o, rresp_o});
      else if ({rdata_o, rresp_o} !== exp_r[0]) $display("FAIL r_order got %h required %h", {rdata_o, rresp_o}, exp_r[0]);
      else n_pass++;
      if (exp_r.size() > 0) void'(exp_r.pop_front());
    end
    if (bpull) n_bpull++;
    if (rpull) n_rpull++;
    if (wpush && !bhs) wr_cnt_m++;
    else if (bhs && !wpush && wr_cnt_m > 0) wr_cnt_m--;
    if (rpush && !rhs) rd_cnt_m++;
    else if (rhs && !rpush && rd_cnt_m > 0) rd_cnt_m--;

    @(posedge aclk_i);
    #1;
    if (awhs) begin void'(aw_q.pop_front()); awvalid_i = 1'b0; end
    if (whs)  begin void'(w_q.pop_front());  wvalid_i  = 1'b0; end
    if (arhs) begin void'(ar_q.pop_front()); arvalid_i = 1'b0; end
    if (bpull && bq.size() > 0) void'(bq.pop_front());
    if (rpull && rq.size() > 0) void'(rq.pop_front());
    if (auto_resp && wpush) begin
      resp = 2'($urandom_range(3)); bq.push_back(resp); exp_b.push_back(resp);
    end
    if (auto_resp && rpush) begin
      rent = {32'($urandom), 2'($urandom_range(3))}; rq.push_back(rent); exp_r.push_back(rent);
    end

    n_checks++;
    if (wr_outst_o !== 4'(wr_cnt_m)) $display("FAIL wr_outst got %0d required %0d", wr_outst_o, wr_cnt_m);
    else n_pass++;
    n_checks++;
    if (rd_outst_o !== 4'(rd_cnt_m)) $display("FAIL rd_outst got %0d required %0d", rd_outst_o, rd_cnt_m);
    else n_pass++;
    if (bhold) begin
      n_checks++;
      if (bvalid_o !== 1'b1 || bresp_o !== bresp_prev)
        $display("FAIL b_stable got v=%b r=%h required v=1 r=%h", bvalid_o, bresp_o, bresp_prev);
      else n_pass++;
    end
    if (rhold) begin
      n_checks++;
      if (rvalid_o !== 1'b1 || {rdata_o, rresp_o} !== r_prev)
        $display("FAIL r_stable got v=%b d=%h required v=1 d=%h", rvalid_o, {rdata_o, rresp_o}, r_prev);
      else n_pass++;
    end
    present();
    #1;
  endtask

  task automatic send_aw(input logic [AW-1:0] a);
    aw_q.push_back(a);
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
    w_q.push_back({d, s});
  endtask

  task automatic send_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    send_aw(a); send_w(d, s); exp_wr.push_back({a, d, s});
  endtask

  task automatic send_read(input logic [AW-1:0] a);
    ar_q.push_back(a); exp_rd.push_back(a);
  endtask

  task automatic clear_bench();
    aw_q.delete(); w_q.delete(); ar_q.delete(); exp_wr.delete(); exp_rd.delete();
    bq.delete(); exp_b.delete(); rq.delete(); exp_r.delete();
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0; bready_i = 1'b0; rready_i = 1'b0;
    wr_req_full_i = 1'b0; rd_req_full_i = 1'b0;
    wr_cnt_m = 0; rd_cnt_m = 0;
  endtask

  task automatic drain_writes();
    int n;
    n = wr_cnt_m;
    for (int i = 0; i < n; i++) begin bq.push_back(2'b00); exp_b.push_back(2'b00); end
    bready_i = 1'b1; present(); #1;
    for (int i = 0; i < 40 && (wr_outst_o != 0 || bvalid_o); i++) tick();
    n_checks++;
    if (wr_outst_o !== 4'd0 || bvalid_o !== 1'b0) $display("FAIL drain_wr got outst=%0d bvalid=%b required 0 0", wr_outst_o, bvalid_o);
    else n_pass++;
    bready_i = 1'b0;
  endtask

  task automatic drain_reads();
    int n;
    logic [DW+1:0] e;
    n = rd_cnt_m;
    for (int i = 0; i < n; i++) begin e = {32'($urandom), 2'b00}; rq.push_back(e); exp_r.push_back(e); end
    rready_i = 1'b1; present(); #1;
    for (int i = 0; i < 40 && (rd_outst_o != 0 || rvalid_o); i++) tick();
    n_checks++;
    if (rd_outst_o !== 4'd0 || rvalid_o !== 1'b0) $display("FAIL drain_rd got outst=%0d rvalid=%b required 0 0", rd_outst_o, rvalid_o);
    else n_pass++;
    rready_i = 1'b0;
  endtask

  task automatic test_reset();
    areset_n_i = 1'b0;
    clear_bench(); present();
    #3;
    n_checks++;
    if ({awready_o, wready_o, arready_o} !== 3'b111) $display("FAIL reset_ready got %b required 111", {awready_o, wready_o, arready_o});
    else n_pass++;
    n_checks++;
    if ({bvalid_o, rvalid_o, wr_req_push_o, rd_req_push_o, wr_resp_pull_o, rd_resp_pull_o} !== 6'b0)
      $display("FAIL reset_strobes got %b required 000000",
               {bvalid_o, rvalid_o, wr_req_push_o, rd_req_push_o, wr_resp_pull_o, rd_resp_pull_o});
    else n_pass++;
    n_checks++;
    if ({bresp_o, rresp_o, rdata_o, wr_outst_o, rd_outst_o} !== '0)
      $display("FAIL reset_values got %h required 0", {bresp_o, rresp_o, rdata_o, wr_outst_o, rd_outst_o});
    else n_pass++;
    @(negedge aclk_i); areset_n_i = 1'b1;
    @(posedge aclk_i); #2;
  endtask

  task automatic test_single_write();
    logic [WRW-1:0] req;
    req = {28'h0000010, 32'hDEADBEEF, 4'hF};
    send_write(28'h0000010, 32'hDEADBEEF, 4'hF); present(); #1;
    tick();
    n_checks++;
    if (wr_req_push_o !== 1'b1 || wr_req_data_o !== req)
      $display("FAIL single_push got p=%b d=%h required p=1 d=%h", wr_req_push_o, wr_req_data_o, req);
    else n_pass++;
    n_checks++;
    if (awready_o !== 1'b0 || wready_o !== 1'b0) $display("FAIL single_held_ready got %b%b required 00", awready_o, wready_o);
    else n_pass++;
    tick();
    n_checks++;
    if (wr_outst_o !== 4'd1 || wr_req_push_o !== 1'b0 || awready_o !== 1'b1)
      $display("FAIL single_after got outst=%0d p=%b awr=%b required 1 0 1", wr_outst_o, wr_req_push_o, awready_o);
    else n_pass++;
    drain_writes();
  endtask

  task automatic test_w_before_aw();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int p0;
    a = AW'($urandom); d = $urandom;
    send_w(d, 4'h3); present(); #1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wready_o !== 1'b0 || wr_req_push_o !== 1'b0) $display("FAIL w_wait got wr=%b p=%b required 0 0", wready_o, wr_req_push_o);
      else n_pass++;
      tick();
    end
    p0 = n_wpush;
    send_aw(a); exp_wr.push_back({a, d, 4'h3}); present(); #1;
    tick();
    n_checks++;
    if (wr_req_push_o !== 1'b1) $display("FAIL w_first_push got %b required 1", wr_req_push_o);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (n_wpush - p0 !== 1) $display("FAIL w_first_count got %0d required 1", n_wpush - p0);
    else n_pass++;
    drain_writes();
  endtask

  task automatic test_req_full();
    wr_req_full_i = 1'b1;
    send_write(AW'($urandom), $urandom, 4'hA); present(); #1;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({wr_req_push_o, awready_o, wready_o} !== 3'b000)
        $display("FAIL full_block got %b required 000", {wr_req_push_o, awready_o, wready_o});
      else n_pass++;
      tick();
    end
    wr_req_full_i = 1'b0; #1;
    n_checks++;
    if (wr_req_push_o !== 1'b1) $display("FAIL full_release got %b required 1", wr_req_push_o);
    else n_pass++;
    tick();
    drain_writes();
  endtask

  task automatic test_b_backpressure();
    int p0;
    send_write(AW'($urandom), $urandom, 4'hF);
    send_write(AW'($urandom), $urandom, 4'h1);
    present(); #1;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (wr_outst_o !== 4'd2) $display("FAIL bp_outst got %0d required 2", wr_outst_o);
    else n_pass++;
    bready_i = 1'b0;
    bq.push_back(2'b00); exp_b.push_back(2'b00);
    bq.push_back(2'b10); exp_b.push_back(2'b10);
    present(); #1;
    p0 = n_bpull;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bvalid_o !== 1'b1 || bresp_o !== 2'b00 || wr_resp_pull_o !== 1'b0)
        $display("FAIL bp_hold got v=%b r=%h pull=%b required 1 0 0", bvalid_o, bresp_o, wr_resp_pull_o);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (n_bpull - p0 !== 1) $display("FAIL bp_pulls got %0d required 1", n_bpull - p0);
    else n_pass++;
    bready_i = 1'b1; #1;
    n_checks++;
    if (wr_resp_pull_o !== 1'b1) $display("FAIL bp_b2b_pull got %b required 1", wr_resp_pull_o);
    else n_pass++;
    tick();
    n_checks++;
    if (bvalid_o !== 1'b1 || bresp_o !== 2'b10 || wr_outst_o !== 4'd1)
      $display("FAIL bp_second got v=%b r=%h outst=%0d required 1 2 1", bvalid_o, bresp_o, wr_outst_o);
    else n_pass++;
    tick();
    n_checks++;
    if (bvalid_o !== 1'b0 || wr_outst_o !== 4'd0)
      $display("FAIL bp_done got v=%b outst=%0d required 0 0", bvalid_o, wr_outst_o);
    else n_pass++;
    bready_i = 1'b0;
  endtask

  task automatic test_max_outst_reads();
    int p0;
    logic [DW+1:0] e;
    p0 = n_rpush;
    for (int i = 0; i < 5; i++) send_read(AW'($urandom));
    present(); #1;
    for (int i = 0; i < 14; i++) tick();
    n_checks++;
    if (n_rpush - p0 !== 4 || arready_o !== 1'b0 || rd_outst_o !== 4'd4)
      $display("FAIL max_block got pushes=%0d arr=%b outst=%0d required 4 0 4", n_rpush - p0, arready_o, rd_outst_o);
    else n_pass++;
    e = {32'($urandom), 2'b00}; rq.push_back(e); exp_r.push_back(e);
    rready_i = 1'b1; present(); #1;
    tick(); tick();
    n_checks++;
    if (rd_req_push_o !== 1'b1) $display("FAIL max_release got %b required 1", rd_req_push_o);
    else n_pass++;
    tick();
    n_checks++;
    if (n_rpush - p0 !== 5 || rd_outst_o !== 4'd4)
      $display("FAIL max_after got pushes=%0d outst=%0d required 5 4", n_rpush - p0, rd_outst_o);
    else n_pass++;
    drain_reads();
  endtask

  task automatic test_reset_midflight();
    send_write(AW'($urandom), $urandom, 4'hF); present(); #1;
    tick(); tick();
    bready_i = 1'b0; bq.push_back(2'b00); exp_b.push_back(2'b00); present(); #1;
    tick();
    send_aw(AW'($urandom)); present(); #1;
    tick();
    n_checks++;
    if (bvalid_o !== 1'b1 || awready_o !== 1'b0) $display("FAIL mid_pre got bv=%b awr=%b required 1 0", bvalid_o, awready_o);
    else n_pass++;
    #2;
    areset_n_i = 1'b0;
    #1;
    n_checks++;
    if (bvalid_o !== 1'b0 || awready_o !== 1'b1 || wr_outst_o !== 4'd0 || rd_outst_o !== 4'd0)
      $display("FAIL mid_reset got bv=%b awr=%b wo=%0d ro=%0d required 0 1 0 0", bvalid_o, awready_o, wr_outst_o, rd_outst_o);
    else n_pass++;
    clear_bench(); present();
    @(posedge aclk_i); @(posedge aclk_i);
    @(negedge aclk_i); areset_n_i = 1'b1;
    @(posedge aclk_i); #2;
  endtask

  task automatic test_random_traffic();
    int cyc;
    valid_pct = 60; auto_resp = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send_write(AW'($urandom), $urandom, SW'($urandom));
      send_read(AW'($urandom));
    end
    present(); #1;
    cyc = 0;
    while (cyc < 3000 && (exp_wr.size() + exp_rd.size() + exp_b.size() + exp_r.size()) != 0) begin
      wr_req_full_i = ($urandom_range(3) == 0);
      rd_req_full_i = ($urandom_range(3) == 0);
      bready_i = ($urandom_range(1) == 1);
      rready_i = ($urandom_range(1) == 1);
      #1;
      tick();
      cyc++;
    end
    n_checks++;
    if ((exp_wr.size() + exp_rd.size() + exp_b.size() + exp_r.size()) != 0)
      $display("FAIL rand_timeout got %0d pending required 0", exp_wr.size() + exp_rd.size() + exp_b.size() + exp_r.size());
    else n_pass++;
    n_checks++;
    if (wr_outst_o !== 4'd0 || rd_outst_o !== 4'd0)
      $display("FAIL rand_final_outst got %0d/%0d required 0/0", wr_outst_o, rd_outst_o);
    else n_pass++;
    valid_pct = 100; auto_resp = 1'b0;
    wr_req_full_i = 1'b0; rd_req_full_i = 1'b0; bready_i = 1'b0; rready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_w_before_aw();
    test_req_full();
    test_b_backpressure();
    test_max_outst_reads();
    test_reset_midflight();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
